uart_rx_ctrl: RTL

Receive-side controller for the UART receiver. It buffers received characters with their parity-error flags in a show-ahead FIFO and presents them to a consumer over a valid/ready stream. It tracks overrun and raises an idle-timeout interrupt. It also owns the receiver's configuration (parity, stop bits, clock divider) and applies new settings only when the line is quiet or the receiver is disabled. It sits between the uart_rx instance and the host/bus logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-setting encodings, reset divider and the
// receive-controller configuration FSM state type.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_e;

  typedef enum logic [0:0] {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  localparam logic [15:0] RST_CLK_DIV = 16'd54;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_dout while not empty.
module uart_sync_fifo #(
  parameter int unsigned DW    = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DW-1:0]            i_din,
  output logic [DW-1:0]            o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign w_pop  = i_pop && (r_level != '0);
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: character FIFO, overrun/idle-timeout flags and
// deferred line configuration. Optional idle timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_en,
  input  logic                     cfg_wr,
  input  logic [1:0]               cfg_w_parity,
  input  logic [1:0]               cfg_w_stop,
  input  logic [15:0]              cfg_w_div,
  output logic [1:0]               cfg_parity,
  output logic [1:0]               cfg_stop_bits,
  output logic [15:0]              cfg_clk_div,
  output logic                     cfg_pending,
  input  logic [WIDTH-1:0]         rx_dout,
  input  logic                     rx_valid,
  input  logic                     parity_err,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_perr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     timeout_irq,
  input  logic                     irq_clr
);
  import uart_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [0:0] ST_IDLE    = CFG_IDLE;
  localparam logic [0:0] ST_PENDING = CFG_PENDING;

  logic [WIDTH:0]  w_head;
  logic [LW-1:0]   w_level;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_apply;
  logic            r_overrun;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic            w_ld_shadow;
  logic            w_ld_active;
  logic            r_pending;
  logic [1:0]      r_sh_parity;
  logic [1:0]      r_sh_stop;
  logic [15:0]     r_sh_div;
  logic [1:0]      r_cfg_parity;
  logic [1:0]      r_cfg_stop;
  logic [15:0]     r_cfg_div;

  assign w_pop  = !w_empty && m_ready;
  assign w_push = rx_valid && rx_en && (!w_full || w_pop);
  assign w_drop = rx_valid && rx_en && w_full && !w_pop;

  uart_sync_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({parity_err, rx_dout}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign m_data  = w_head[WIDTH-1:0];
  assign m_perr  = w_head[WIDTH];
  assign m_valid = !w_empty;
  assign level   = w_level;

  // Sticky overrun; a drop in the same cycle as irq_clr keeps it set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (irq_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int unsigned QW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(TIMEOUT_TICKS);

  logic [15:0]   r_tick_cnt;
  logic [QW-1:0] r_quiet_cnt;
  logic          r_timeout;
  logic          w_tick;
  logic          w_quiet;
  logic          w_drain;

  // >= recovers cleanly if the divider shrinks below the running count
  assign w_tick  = (r_tick_cnt >= r_cfg_div);
  assign w_quiet = (r_quiet_cnt == QUIET_MAX);
  assign w_drain = w_pop && !w_push && (w_level == LW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      r_quiet_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
      if (w_push || w_pop || cfg_wr) begin
        r_quiet_cnt <= '0;
      end else if (w_tick && !w_quiet) begin
        r_quiet_cnt <= r_quiet_cnt + QW'(1);
      end
    end
  end

  // Emptying the FIFO withdraws the interrupt; otherwise set beats irq_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_drain || w_empty) begin
      r_timeout <= 1'b0;
    end else if (w_quiet) begin
      r_timeout <= 1'b1;
    end else if (irq_clr) begin
      r_timeout <= 1'b0;
    end
  end

  assign timeout_irq = r_timeout;
  assign w_apply     = !rx_en || (w_quiet && !w_push);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT_TICKS;
  assign timeout_irq      = 1'b0;
  assign w_apply          = !rx_en;
`endif

  // Configuration FSM: a new write always wins over a same-cycle apply
  always_comb begin
    w_state_nxt = r_state;
    w_ld_shadow = 1'b0;
    w_ld_active = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_wr) begin
          w_state_nxt = ST_PENDING;
          w_ld_shadow = 1'b1;
        end
      end
      ST_PENDING: begin
        if (cfg_wr) begin
          w_ld_shadow = 1'b1;
        end else if (w_apply) begin
          w_state_nxt = ST_IDLE;
          w_ld_active = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pending    <= 1'b0;
      r_sh_parity  <= PARITY_NONE;
      r_sh_stop    <= STOP_1;
      r_sh_div     <= RST_CLK_DIV;
      r_cfg_parity <= PARITY_NONE;
      r_cfg_stop   <= STOP_1;
      r_cfg_div    <= RST_CLK_DIV;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (w_state_nxt == ST_PENDING);
      if (w_ld_shadow) begin
        r_sh_parity <= cfg_w_parity;
        r_sh_stop   <= cfg_w_stop;
        r_sh_div    <= cfg_w_div;
      end
      if (w_ld_active) begin
        r_cfg_parity <= r_sh_parity;
        r_cfg_stop   <= r_sh_stop;
        r_cfg_div    <= r_sh_div;
      end
    end
  end

  assign cfg_parity    = r_cfg_parity;
  assign cfg_stop_bits = r_cfg_stop;
  assign cfg_clk_div   = r_cfg_div;
  assign cfg_pending   = r_pending;

endmodule
